// File: rtl/int_pkg.sv
// Shared types and constants for the 6502 interrupt/BRK entry sequencer.
package int_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DUMMY,
    PUSH_H,
    PUSH_L,
    PUSH_P,
    VEC_L,
    VEC_H
  } state_t;

  typedef enum logic [1:0] {
    RST,
    NMI,
    IRQ,
    BRK
  } kind_t;

  localparam logic [15:0] VEC_NMI = 16'hFFFA;
  localparam logic [15:0] VEC_RST = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ = 16'hFFFE;

  localparam int B_BIT = 4;
  localparam int U_BIT = 5;

  // Status byte as it lands on the stack: unused bit forced high, B only for BRK.
  function automatic logic [7:0] push_status(input logic [7:0] p, input kind_t kind);
    logic [7:0] r;
    r        = p;
    r[U_BIT] = 1'b1;
    r[B_BIT] = (kind == BRK);
    return r;
  endfunction

endpackage

// File: rtl/int_entry_nmi_edge.sv
// NMI rising-edge detector with a pending latch; a new edge beats a
// coincident clear so no NMI is ever lost.
module nmi_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic nmi_req,
  input  logic clr,
  output logic pend
);

  logic req_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q <= 1'b0;
      pend  <= 1'b0;
    end else begin
      // NOTE: non-blocking here so pend sees the previous req_q, not the one
      // being written this edge; blocking would erase the edge.
      req_q <= nmi_req;
      pend  <= (pend & ~clr) | (nmi_req & ~req_q);
    end
  end

endmodule

// File: rtl/int_entry.sv
// Interrupt/BRK entry sequencer: at an instruction boundary it owns the bus
// for six cycles to push PC/P (dummy stack reads on reset) and fetch the vector.
module int_entry
  import int_pkg::*;
#(
  parameter logic [7:0] STACK_PAGE = 8'h01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sync,
  input  logic        rdy,
  input  logic        rst_req,
  input  logic        nmi_req,
  input  logic        irq_req,
  input  logic        brk,
  input  logic        i_flag,
  input  logic [15:0] pc,
  input  logic [7:0]  p,
  input  logic [7:0]  sp,
  input  logic [7:0]  din,
  output logic        busy,
  output logic [15:0] addr,
  output logic [7:0]  dout,
  output logic        rw,
  output logic        sp_dec,
  output logic        pc_load,
  output logic [15:0] pc_new,
  output logic        set_i,
  output logic        take_int
);

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d;
  logic [15:0] pc_q;
  logic [15:0] vec_q, vec_d;
  logic [7:0]  p_q, sp_q, vec_lo_q;
  logic [7:0]  sp_m1, sp_m2;
  logic        nmi_pend, nmi_clr;
  logic        start, hw_start, is_push;

  nmi_edge u_nmi_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .nmi_req (nmi_req),
    .clr     (nmi_clr),
    .pend    (nmi_pend)
  );

  assign is_push = (state_q == PUSH_H) || (state_q == PUSH_L) || (state_q == PUSH_P);
  assign sp_m1   = sp_q - 8'd1;
  assign sp_m2   = sp_q - 8'd2;

  // Next-state logic. set_i high means the core is still one cycle away from
  // seeing I=1, so IRQ is masked in that cycle on its behalf.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would infer a latch.
    state_d  = state_q;
    kind_d   = kind_q;
    vec_d    = vec_q;
    start    = 1'b0;
    hw_start = 1'b0;
    nmi_clr  = 1'b0;
    if (rdy) begin
      unique case (state_q)
        IDLE: begin
          if (sync && rst_req) begin
            kind_d   = RST;
            hw_start = 1'b1;
          end else if (sync && nmi_pend) begin
            kind_d   = NMI;
            hw_start = 1'b1;
          end else if (sync && irq_req && !i_flag && !set_i) begin
            kind_d   = IRQ;
            hw_start = 1'b1;
          end else if (brk) begin
            kind_d = BRK;
            start  = 1'b1;
          end
          if (hw_start) start = 1'b1;
          if (start) state_d = DUMMY;
        end
        DUMMY:  state_d = PUSH_H;
        PUSH_H: state_d = PUSH_L;
        PUSH_L: state_d = PUSH_P;
        PUSH_P: begin
          state_d = VEC_L;
          if (kind_q == RST) begin
            vec_d = VEC_RST;
          end else if (nmi_pend) begin
            vec_d   = VEC_NMI;
            nmi_clr = 1'b1;
          end else begin
            vec_d = VEC_IRQ;
          end
        end
        VEC_L:   state_d = VEC_H;
        VEC_H:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Bus decode from state and latched context; reset entry turns pushes into reads.
  always_comb begin
    addr = 16'h0000;
    dout = 8'h00;
    rw   = 1'b1;
    unique case (state_q)
      DUMMY:  addr = pc_q;
      PUSH_H: begin
        addr = {STACK_PAGE, sp_q};
        dout = pc_q[15:8];
      end
      PUSH_L: begin
        addr = {STACK_PAGE, sp_m1};
        dout = pc_q[7:0];
      end
      PUSH_P: begin
        addr = {STACK_PAGE, sp_m2};
        dout = push_status(p_q, kind_q);
      end
      VEC_L:   addr = vec_q;
      VEC_H:   addr = vec_q | 16'h0001;
      default: addr = 16'h0000;
    endcase
    if (is_push && kind_q == RST) begin
      dout = 8'h00;
    end
    if (is_push && kind_q != RST) begin
      rw = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      kind_q   <= RST;
      pc_q     <= 16'h0000;
      p_q      <= 8'h00;
      sp_q     <= 8'h00;
      vec_q    <= 16'h0000;
      vec_lo_q <= 8'h00;
      busy     <= 1'b0;
      sp_dec   <= 1'b0;
      pc_load  <= 1'b0;
      set_i    <= 1'b0;
      take_int <= 1'b0;
      pc_new   <= 16'h0000;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      vec_q    <= vec_d;
      busy     <= (state_d != IDLE);
      take_int <= hw_start;
      sp_dec   <= rdy && is_push;
      pc_load  <= rdy && (state_q == VEC_H);
      set_i    <= rdy && (state_q == VEC_H);
      if (start) begin
        pc_q <= pc;
        p_q  <= p;
        sp_q <= sp;
      end
      if (rdy && state_q == VEC_L) vec_lo_q <= din;
      if (rdy && state_q == VEC_H) pc_new <= {din, vec_lo_q};
    end
  end

endmodule

// File: tb/tb_int_entry.sv
// Self-checking bench for int_entry: directed scenarios plus randomized entries
// compared against a transaction-level model of the expected bus sequence.
module tb_int_entry;

  localparam int K_RST  = 0;
  localparam int K_NMI  = 1;
  localparam int K_IRQ  = 2;
  localparam int K_BRK  = 3;
  localparam int K_NONE = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sync = 1'b0, rdy = 1'b1;
  logic        rst_req = 1'b0, nmi_req = 1'b0, irq_req = 1'b0, brk = 1'b0, i_flag = 1'b0;
  logic [15:0] pc = 16'h0000;
  logic [7:0]  p = 8'h00, sp = 8'hFD;
  logic [7:0]  din;
  logic        busy, rw, sp_dec, pc_load, set_i, take_int;
  logic [15:0] addr, pc_new;
  logic [7:0]  dout;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] a;
    logic        rw;
    logic [7:0]  d;
    logic        chk_d;
  } bus_t;

  bus_t        got_q[$];
  bus_t        exp_q[$];
  int          busy_cnt, spd_cnt, pcl_cnt, seti_cnt, take_cnt;
  logic [15:0] pcn_got, exp_pcn;
  logic [7:0]  vec_tbl [0:5];

  int_entry #(.STACK_PAGE(8'h01)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sync     (sync),
    .rdy      (rdy),
    .rst_req  (rst_req),
    .nmi_req  (nmi_req),
    .irq_req  (irq_req),
    .brk      (brk),
    .i_flag   (i_flag),
    .pc       (pc),
    .p        (p),
    .sp       (sp),
    .din      (din),
    .busy     (busy),
    .addr     (addr),
    .dout     (dout),
    .rw       (rw),
    .sp_dec   (sp_dec),
    .pc_load  (pc_load),
    .pc_new   (pc_new),
    .set_i    (set_i),
    .take_int (take_int)
  );

  always #5 clk = ~clk;

  // Bench memory: vector bytes from the table, anything else a fixed pattern.
  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    if (a >= 16'hFFFA) return vec_tbl[int'(a - 16'hFFFA)];
    return a[7:0] ^ 8'h3C;
  endfunction

  assign din = mem_rd(addr);

  // Bus monitor: log each completed bus cycle and count strobes.
  always @(negedge clk) begin
    if (busy && rdy) got_q.push_back('{addr, rw, dout, 1'b0});
    if (busy)     busy_cnt++;
    if (sp_dec)   spd_cnt++;
    if (pc_load)  begin pcl_cnt++; pcn_got = pc_new; end
    if (set_i)    seti_cnt++;
    if (take_int) take_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_q.delete();
    busy_cnt = 0; spd_cnt = 0; pcl_cnt = 0; seti_cnt = 0; take_cnt = 0;
    pcn_got = 16'hxxxx;
  endtask

  // Advance until pc_load is seen (returns in that cycle); optional random stalls.
  task automatic wait_pcl(input bit rnd_rdy, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (pc_load) begin ok = 1'b1; rdy = 1'b1; return; end
      rdy = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
    rdy = 1'b1;
  endtask

  // Reference model: the six bus cycles an entry of this kind must produce.
  task automatic build_exp(input int kind, input logic [15:0] rpc, input logic [7:0] rp,
                           input logic [7:0] rsp, input bit pend);
    logic [15:0] vec;
    logic [7:0]  pb, sa, byt;
    bit          rd;
    exp_q.delete();
    rd  = (kind == K_RST);
    vec = rd ? 16'hFFFC : (pend ? 16'hFFFA : 16'hFFFE);
    pb  = (rp & 8'hCF) | 8'h20 | ((kind == K_BRK) ? 8'h10 : 8'h00);
    exp_q.push_back('{rpc, 1'b1, 8'h00, 1'b0});
    for (int i = 0; i < 3; i++) begin
      sa  = rsp - 8'(i);
      byt = (i == 0) ? rpc[15:8] : (i == 1) ? rpc[7:0] : pb;
      exp_q.push_back('{{8'h01, sa}, rd, rd ? 8'h00 : byt, 1'b1});
    end
    exp_q.push_back('{vec, 1'b1, 8'h00, 1'b0});
    exp_q.push_back('{vec + 16'd1, 1'b1, 8'h00, 1'b0});
    exp_pcn = {mem_rd(vec + 16'd1), mem_rd(vec)};
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rw !== 1'b1)       begin failures++; $display("FAIL reset_rw got=%b exp=1", rw); end
    checks++; if (addr !== 16'h0000) begin failures++; $display("FAIL reset_addr got=%h exp=0000", addr); end
    checks++; if (dout !== 8'h00)    begin failures++; $display("FAIL reset_dout got=%h exp=00", dout); end
    checks++; if ({sp_dec, pc_load, set_i, take_int} !== 4'b0000)
      begin failures++; $display("FAIL reset_strobes got=%b exp=0000", {sp_dec, pc_load, set_i, take_int}); end
    checks++; if (pc_new !== 16'h0000) begin failures++; $display("FAIL reset_pc_new got=%h exp=0000", pc_new); end
    rst_n = 1'b1;
    step(3);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_irq();
    bit ok;
    clear_mon();
    pc = 16'hC123; p = 8'h20; sp = 8'hFD; irq_req = 1'b1; i_flag = 1'b0; sync = 1'b1;
    build_exp(K_IRQ, pc, p, sp, 1'b0);
    step(1);
    sync = 1'b0;
    wait_pcl(1'b0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL irq_timeout got=no pc_load exp=pc_load"); end
    // Core refetches with sync while IRQ is still asserted and I not yet visible.
    sync = 1'b1;
    step(1);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL irq_retrigger busy got=%b exp=0", busy); end
    sync = 1'b0; irq_req = 1'b0;
    step(1);
    checks++; if (got_q.size() != 6) begin failures++; $display("FAIL irq_len got=%0d exp=6", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].a !== exp_q[i].a || got_q[i].rw !== exp_q[i].rw || (exp_q[i].chk_d && got_q[i].d !== exp_q[i].d)) begin
        failures++;
        $display("FAIL irq_bus[%0d] got a=%h rw=%b d=%h exp a=%h rw=%b d=%h", i,
                 got_q[i].a, got_q[i].rw, got_q[i].d, exp_q[i].a, exp_q[i].rw, exp_q[i].d);
      end
    end
    checks++; if (pcn_got !== 16'h1234) begin failures++; $display("FAIL irq_pc_new got=%h exp=1234", pcn_got); end
    checks++; if (spd_cnt != 3)  begin failures++; $display("FAIL irq_sp_dec got=%0d exp=3", spd_cnt); end
    checks++; if (pcl_cnt != 1 || seti_cnt != 1)
      begin failures++; $display("FAIL irq_pc_load_set_i got=%0d/%0d exp=1/1", pcl_cnt, seti_cnt); end
    checks++; if (take_cnt != 1) begin failures++; $display("FAIL irq_take_int got=%0d exp=1", take_cnt); end
    checks++; if (busy_cnt != 6) begin failures++; $display("FAIL irq_busy_cycles got=%0d exp=6", busy_cnt); end
  endtask

  task automatic test_brk();
    bit ok;
    clear_mon();
    pc = 16'h8002; p = 8'h00; sp = 8'hFD; brk = 1'b1;
    build_exp(K_BRK, pc, p, sp, 1'b0);
    step(1);
    brk = 1'b0;
    wait_pcl(1'b0, ok);
    step(1);
    checks++; if (!ok) begin failures++; $display("FAIL brk_timeout got=no pc_load exp=pc_load"); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].a !== exp_q[i].a || got_q[i].rw !== exp_q[i].rw || (exp_q[i].chk_d && got_q[i].d !== exp_q[i].d)) begin
        failures++;
        $display("FAIL brk_bus[%0d] got a=%h rw=%b d=%h exp a=%h rw=%b d=%h", i,
                 got_q[i].a, got_q[i].rw, got_q[i].d, exp_q[i].a, exp_q[i].rw, exp_q[i].d);
      end
    end
    checks++; if (got_q.size() < 4 || got_q[3].d !== 8'h30)
      begin failures++; $display("FAIL brk_pushed_p got=%h exp=30", (got_q.size() < 4) ? 8'hxx : got_q[3].d); end
    checks++; if (take_cnt != 0) begin failures++; $display("FAIL brk_take_int got=%0d exp=0", take_cnt); end
    // Masked IRQ at an instruction boundary must not start.
    clear_mon();
    irq_req = 1'b1; i_flag = 1'b1; sync = 1'b1;
    step(3);
    checks++; if (busy !== 1'b0 || take_cnt != 0)
      begin failures++; $display("FAIL irq_masked got busy=%b take=%0d exp busy=0 take=0", busy, take_cnt); end
    irq_req = 1'b0; i_flag = 1'b0; sync = 1'b0;
    step(1);
  endtask

  task automatic test_rst_entry();
    bit ok;
    int writes;
    clear_mon();
    pc = 16'($urandom); p = 8'($urandom); sp = 8'($urandom);
    rst_req = 1'b1; sync = 1'b1;
    build_exp(K_RST, pc, p, sp, 1'b0);
    step(1);
    rst_req = 1'b0; sync = 1'b0;
    wait_pcl(1'b0, ok);
    step(1);
    checks++; if (!ok) begin failures++; $display("FAIL rst_timeout got=no pc_load exp=pc_load"); end
    writes = 0;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (got_q[i].rw === 1'b0) writes++;
      checks++;
      if (got_q[i].a !== exp_q[i].a || got_q[i].rw !== exp_q[i].rw || (exp_q[i].chk_d && got_q[i].d !== exp_q[i].d)) begin
        failures++;
        $display("FAIL rst_bus[%0d] got a=%h rw=%b d=%h exp a=%h rw=%b d=%h", i,
                 got_q[i].a, got_q[i].rw, got_q[i].d, exp_q[i].a, exp_q[i].rw, exp_q[i].d);
      end
    end
    checks++; if (writes != 0)   begin failures++; $display("FAIL rst_writes got=%0d exp=0", writes); end
    checks++; if (spd_cnt != 3)  begin failures++; $display("FAIL rst_sp_dec got=%0d exp=3", spd_cnt); end
    checks++; if (pcn_got !== exp_pcn) begin failures++; $display("FAIL rst_pc_new got=%h exp=%h", pcn_got, exp_pcn); end
  endtask

  task automatic test_nmi_hijack();
    bit ok;
    logic [15:0] pc2;
    clear_mon();
    pc = 16'h4567; p = 8'hC3; sp = 8'hF0; irq_req = 1'b1; sync = 1'b1;
    build_exp(K_IRQ, pc, p, sp, 1'b1);
    step(1);                 // DUMMY
    sync = 1'b0; irq_req = 1'b0;
    step(2);                 // PUSH_L
    nmi_req = 1'b1;
    step(2);                 // VEC_L
    nmi_req = 1'b0;
    step(1);                 // VEC_H: second edge
    nmi_req = 1'b1;
    wait_pcl(1'b0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL nmi_timeout got=no pc_load exp=pc_load"); end
    pc2 = exp_pcn; pc = pc2; sync = 1'b1;
    step(1);
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].a !== exp_q[i].a || got_q[i].rw !== exp_q[i].rw || (exp_q[i].chk_d && got_q[i].d !== exp_q[i].d)) begin
        failures++;
        $display("FAIL hijack_bus[%0d] got a=%h rw=%b d=%h exp a=%h rw=%b d=%h", i,
                 got_q[i].a, got_q[i].rw, got_q[i].d, exp_q[i].a, exp_q[i].rw, exp_q[i].d);
      end
    end
    checks++; if (pcn_got !== exp_pcn) begin failures++; $display("FAIL hijack_pc_new got=%h exp=%h", pcn_got, exp_pcn); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL nmi_second_start busy got=%b exp=1", busy); end
    clear_mon();
    sync = 1'b0; nmi_req = 1'b0;
    build_exp(K_NMI, pc2, p, sp, 1'b1);
    wait_pcl(1'b0, ok);
    step(1);
    checks++; if (!ok) begin failures++; $display("FAIL nmi2_timeout got=no pc_load exp=pc_load"); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].a !== exp_q[i].a || got_q[i].rw !== exp_q[i].rw || (exp_q[i].chk_d && got_q[i].d !== exp_q[i].d)) begin
        failures++;
        $display("FAIL nmi2_bus[%0d] got a=%h rw=%b d=%h exp a=%h rw=%b d=%h", i,
                 got_q[i].a, got_q[i].rw, got_q[i].d, exp_q[i].a, exp_q[i].rw, exp_q[i].d);
      end
    end
    checks++; if (take_cnt != 1) begin failures++; $display("FAIL nmi2_take_int got=%0d exp=1", take_cnt); end
    // Pending NMI consumed: a bare boundary must not start again.
    sync = 1'b1;
    step(2);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL nmi_pend_cleared busy got=%b exp=0", busy); end
    sync = 1'b0;
    step(1);
  endtask

  task automatic test_wrap_stall();
    bit ok;
    logic [15:0] a0;
    logic [7:0]  d0;
    clear_mon();
    pc = 16'($urandom); p = 8'($urandom); sp = 8'h01; brk = 1'b1;
    build_exp(K_BRK, pc, p, sp, 1'b0);
    step(1);                 // DUMMY
    brk = 1'b0;
    step(3);                 // PUSH_P
    rdy = 1'b0; rst_req = 1'b1;
    a0 = addr; d0 = dout;
    checks++; if (a0 !== 16'h01FF) begin failures++; $display("FAIL wrap_addr got=%h exp=01FF", a0); end
    checks++; if (d0 !== ((p & 8'hCF) | 8'h30)) begin failures++; $display("FAIL wrap_p got=%h exp=%h", d0, (p & 8'hCF) | 8'h30); end
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++;
      if (addr !== a0 || dout !== d0 || rw !== 1'b0 || sp_dec !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold[%0d] got a=%h d=%h rw=%b spd=%b exp a=%h d=%h rw=0 spd=0", i, addr, dout, rw, sp_dec, a0, d0);
      end
    end
    rdy = 1'b1;
    wait_pcl(1'b0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL wrap_timeout got=no pc_load exp=pc_load"); end
    sync = 1'b1;             // rst_req raised mid-sequence wins here
    step(1);
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].a !== exp_q[i].a || got_q[i].rw !== exp_q[i].rw || (exp_q[i].chk_d && got_q[i].d !== exp_q[i].d)) begin
        failures++;
        $display("FAIL wrap_bus[%0d] got a=%h rw=%b d=%h exp a=%h rw=%b d=%h", i,
                 got_q[i].a, got_q[i].rw, got_q[i].d, exp_q[i].a, exp_q[i].rw, exp_q[i].d);
      end
    end
    checks++; if (spd_cnt != 3 || busy_cnt != 9)
      begin failures++; $display("FAIL stall_counts got spd=%0d busy=%0d exp spd=3 busy=9", spd_cnt, busy_cnt); end
    clear_mon();
    sync = 1'b0; rst_req = 1'b0;
    wait_pcl(1'b0, ok);
    step(1);
    checks++; if (!ok || take_cnt != 1 || got_q.size() != 6 || got_q[5].a !== 16'hFFFD)
      begin failures++; $display("FAIL rst_after_seq got ok=%b take=%0d len=%0d exp ok=1 take=1 len=6 last=FFFD", ok, take_cnt, got_q.size()); end
  endtask

  task automatic test_abort();
    clear_mon();
    pc = 16'h1111; sp = 8'hFD; irq_req = 1'b1; sync = 1'b1;
    step(1);                 // DUMMY
    sync = 1'b0; irq_req = 1'b0; nmi_req = 1'b1;
    step(2);                 // PUSH_L, NMI now pending
    rst_n = 1'b0; nmi_req = 1'b0;
    step(1);
    checks++; if (busy !== 1'b0 || pc_load !== 1'b0 || sp_dec !== 1'b0 || rw !== 1'b1 || addr !== 16'h0000)
      begin failures++; $display("FAIL abort_state got busy=%b pcl=%b spd=%b rw=%b a=%h exp 0 0 0 1 0000", busy, pc_load, sp_dec, rw, addr); end
    rst_n = 1'b1;
    step(2);
    checks++; if (pcl_cnt != 0) begin failures++; $display("FAIL abort_pc_load got=%0d exp=0", pcl_cnt); end
    sync = 1'b1;
    step(2);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_nmi_pend busy got=%b exp=0", busy); end
    sync = 1'b0;
    step(1);
  endtask

  task automatic test_random();
    bit ok, model_pend, s, r, q, im, b;
    int k;
    logic [15:0] rpc;
    logic [7:0]  rp, rsp;
    model_pend = 1'b0;
    for (int it = 0; it < 30; it++) begin
      step(2);
      if ($urandom_range(0, 2) == 0) begin
        nmi_req = 1'b1; step(1); nmi_req = 1'b0; model_pend = 1'b1;
      end
      clear_mon();
      rpc = 16'($urandom); rp = 8'($urandom); rsp = 8'($urandom);
      s = ($urandom_range(0, 3) != 0); r = ($urandom_range(0, 4) == 0);
      q = 1'($urandom); im = 1'($urandom); b = ($urandom_range(0, 2) == 0);
      if (s && r)               k = K_RST;
      else if (s && model_pend) k = K_NMI;
      else if (s && q && !im)   k = K_IRQ;
      else if (b)               k = K_BRK;
      else                      k = K_NONE;
      pc = rpc; p = rp; sp = rsp; sync = s; rst_req = r; irq_req = q; i_flag = im; brk = b;
      step(1);
      sync = 1'b0; rst_req = 1'b0; irq_req = 1'b0; brk = 1'b0;
      if (k == K_NONE) begin
        step(1);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rand[%0d]_no_start busy got=%b exp=0", it, busy); end
      end else begin
        build_exp(k, rpc, rp, rsp, model_pend);
        wait_pcl(1'b1, ok);
        step(1);
        checks++; if (!ok || got_q.size() != 6)
          begin failures++; $display("FAIL rand[%0d]_seq got ok=%b len=%0d exp ok=1 len=6 kind=%0d", it, ok, got_q.size(), k); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
          checks++;
          if (got_q[i].a !== exp_q[i].a || got_q[i].rw !== exp_q[i].rw || (exp_q[i].chk_d && got_q[i].d !== exp_q[i].d)) begin
            failures++;
            $display("FAIL rand[%0d]_bus[%0d] got a=%h rw=%b d=%h exp a=%h rw=%b d=%h", it, i,
                     got_q[i].a, got_q[i].rw, got_q[i].d, exp_q[i].a, exp_q[i].rw, exp_q[i].d);
          end
        end
        checks++; if (pcn_got !== exp_pcn || spd_cnt != 3 || take_cnt != ((k != K_BRK) ? 1 : 0))
          begin failures++; $display("FAIL rand[%0d]_strobes got pcn=%h spd=%0d take=%0d exp pcn=%h spd=3 kind=%0d", it, pcn_got, spd_cnt, take_cnt, exp_pcn, k); end
        if (k != K_RST) model_pend = 1'b0;
      end
    end
    i_flag = 1'b0;
  endtask

  initial begin
    vec_tbl = '{8'h00, 8'h90, 8'h00, 8'h80, 8'h34, 8'h12};
    step(3);
    test_reset();
    test_irq();
    test_brk();
    test_rst_entry();
    test_nmi_hijack();
    test_wrap_stall();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
